// File: rtl/wfg_arb_pkg.sv
// -----------------------------------------------------------------------------
// wfg_arb_pkg
//   Shared definitions for the two-master Wishbone arbiter in front of wfg_top:
//   FSM state encoding, one-hot grant encodings, the error read-data word
//   returned on a forced abort, and a helper that sizes the watchdog counter.
// -----------------------------------------------------------------------------
package wfg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Read data handed to the owner when a hung access is aborted.
  localparam logic [31:0] WFG_ARB_ERR_DATA = 32'hDEAD_BEEF;

  // One-hot owner encodings as seen on arb_grant_o.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Watchdog width: enough bits to hold the limit, clamped to 8..16 bits.
  function automatic int wdt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/wfg_arb_wdt.sv
// -----------------------------------------------------------------------------
// wfg_arb_wdt
//   Stall watchdog for the arbiter. Counts cycles in which the owner strobes
//   without an acknowledge and flags expiry once LIMIT such cycles have passed.
//   The count saturates at LIMIT until cleared.
// Ports
//   clk        : bus clock
//   srst       : synchronous active-high reset
//   clr        : clear the count (slave acked, or no owner)
//   tick       : one stalled strobe cycle
//   expired_o  : count has reached LIMIT
// -----------------------------------------------------------------------------
module wfg_arb_wdt
  import wfg_arb_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic tick,
  output logic expired_o
);

  localparam int                CW      = wdt_width(LIMIT);
  localparam logic [CW-1:0]     LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/wfg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// wfg_wb_arbiter
//   Two-master Wishbone arbiter in front of the wfg_top register port.
//   Master 0 is the management core, master 1 the pattern sequencer.
//   Ownership is granted per cyc window (registered, one cycle after cyc),
//   round-robin on simultaneous requests, and held for as long as the owner
//   keeps cyc high, so multi-beat accesses stay atomic. Dropping cyc returns
//   the arbiter to IDLE for one dead cycle before the next owner is granted.
//
// Configuration macro
//   WFG_ARB_TIMEOUT_EN : when defined, an access strobed for TIMEOUT_CYCLES
//     cycles without ack is aborted: the owner gets a one-cycle ack carrying
//     WFG_ARB_ERR_DATA, the slave sees cyc/stb low that cycle, the grant is
//     released and arb_timeout_o latches high until reset. When undefined a
//     hung slave holds the grant indefinitely and arb_timeout_o is 0.
//
// Ports
//   io_wbs_clk / io_wbs_rst          : clock, synchronous active-high reset
//   io_m{0,1}_adr/datwr/we/stb/cyc   : master request inputs
//   io_m{0,1}_datrd/ack              : master responses (0 unless owner)
//   io_s_adr/datwr/we/stb/cyc        : muxed request to wfg_top
//   io_s_datrd/ack                   : wfg_top response
//   arb_grant_o                      : one-hot owner, 00 = idle
//   arb_timeout_o                    : sticky abort flag
// -----------------------------------------------------------------------------
module wfg_wb_arbiter
  import wfg_arb_pkg::*;
#(
  parameter int BUSW           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            io_wbs_clk,
  input  logic            io_wbs_rst,
  // master 0
  input  logic [BUSW-1:0] io_m0_adr,
  input  logic [BUSW-1:0] io_m0_datwr,
  output logic [BUSW-1:0] io_m0_datrd,
  input  logic            io_m0_we,
  input  logic            io_m0_stb,
  input  logic            io_m0_cyc,
  output logic            io_m0_ack,
  // master 1
  input  logic [BUSW-1:0] io_m1_adr,
  input  logic [BUSW-1:0] io_m1_datwr,
  output logic [BUSW-1:0] io_m1_datrd,
  input  logic            io_m1_we,
  input  logic            io_m1_stb,
  input  logic            io_m1_cyc,
  output logic            io_m1_ack,
  // slave (wfg_top)
  output logic [BUSW-1:0] io_s_adr,
  output logic [BUSW-1:0] io_s_datwr,
  input  logic [BUSW-1:0] io_s_datrd,
  output logic            io_s_we,
  output logic            io_s_stb,
  output logic            io_s_cyc,
  input  logic            io_s_ack,
  // status
  output logic [1:0]      arb_grant_o,
  output logic            arb_timeout_o
);

  arb_state_e state_d, state_q;
  logic       last_srv_d, last_srv_q;   // master served most recently
  logic       own0, own1;
  logic       abort;

  // Ownership is masked by reset so every output drops while reset is held,
  // including in the cycle a mid-transfer reset is first applied.
  assign own0 = (state_q == ST_OWN0) && !io_wbs_rst;
  assign own1 = (state_q == ST_OWN1) && !io_wbs_rst;

`ifdef WFG_ARB_TIMEOUT_EN
  localparam logic [BUSW-1:0] ERR_DATA = BUSW'(WFG_ARB_ERR_DATA);

  logic wdt_tick, wdt_clr, wdt_expired;
  logic timeout_d, timeout_q;

  // Count only strobes that actually reach the slave and go unanswered.
  assign wdt_tick = ((own0 && io_m0_stb && io_m0_cyc) ||
                     (own1 && io_m1_stb && io_m1_cyc)) && !io_s_ack;
  assign wdt_clr  = !(own0 || own1) || io_s_ack;

  wfg_arb_wdt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk       (io_wbs_clk),
    .srst      (io_wbs_rst),
    .clr       (wdt_clr),
    .tick      (wdt_tick),
    .expired_o (wdt_expired)
  );

  assign abort = wdt_expired && (own0 || own1);

  always_comb begin
    timeout_d = timeout_q | abort;
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign arb_timeout_o = timeout_q;
`else
  localparam logic [BUSW-1:0] ERR_DATA = '0;
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign abort              = 1'b0;
  assign arb_timeout_o      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the master that was not served last wins.
        if (io_m0_cyc && (!io_m1_cyc || last_srv_q)) begin
          state_d = ST_OWN0;
        end else if (io_m1_cyc) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!io_m0_cyc || abort) begin
          state_d    = ST_IDLE;
          last_srv_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!io_m1_cyc || abort) begin
          state_d    = ST_IDLE;
          last_srv_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state_q    <= ST_IDLE;
      last_srv_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus multiplexing
  // ---------------------------------------------------------------------------
  always_comb begin
    io_s_adr    = '0;
    io_s_datwr  = '0;
    io_s_we     = 1'b0;
    io_s_stb    = 1'b0;
    io_s_cyc    = 1'b0;
    io_m0_datrd = '0;
    io_m1_datrd = '0;
    io_m0_ack   = 1'b0;
    io_m1_ack   = 1'b0;
    arb_grant_o = GRANT_NONE;
    if (own0) begin
      arb_grant_o = GRANT_M0;
      io_s_adr    = io_m0_adr;
      io_s_datwr  = io_m0_datwr;
      io_s_we     = io_m0_we;
      // An abort hides the access from the slave and answers it locally.
      io_s_cyc    = io_m0_cyc && !abort;
      io_s_stb    = io_m0_stb && io_m0_cyc && !abort;
      io_m0_ack   = io_s_ack || abort;
      io_m0_datrd = abort ? ERR_DATA : io_s_datrd;
    end else if (own1) begin
      arb_grant_o = GRANT_M1;
      io_s_adr    = io_m1_adr;
      io_s_datwr  = io_m1_datwr;
      io_s_we     = io_m1_we;
      io_s_cyc    = io_m1_cyc && !abort;
      io_s_stb    = io_m1_stb && io_m1_cyc && !abort;
      io_m1_ack   = io_s_ack || abort;
      io_m1_datrd = abort ? ERR_DATA : io_s_datrd;
    end
  end

endmodule

// File: tb/tb_wfg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wfg_wb_arbiter
//   Scenario tasks drive both masters and the slave response; every beat the
//   bench acknowledges is pushed to a scoreboard and checked by a monitor when
//   the slave-side handshake (s_stb & s_ack) appears.
// -----------------------------------------------------------------------------
module tb_wfg_wb_arbiter;

  localparam int BUSW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [BUSW-1:0] m0_adr, m0_datwr, m0_datrd, m1_adr, m1_datwr, m1_datrd;
  logic            m0_we, m0_stb, m0_cyc, m0_ack, m1_we, m1_stb, m1_cyc, m1_ack;
  logic [BUSW-1:0] s_adr, s_datwr, s_datrd;
  logic            s_we, s_stb, s_cyc, s_ack;
  logic [1:0]      grant;
  logic            timeout;

  always #5 clk = ~clk;

  wfg_wb_arbiter #(
    .BUSW           (BUSW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .io_wbs_clk    (clk),
    .io_wbs_rst    (rst),
    .io_m0_adr     (m0_adr),
    .io_m0_datwr   (m0_datwr),
    .io_m0_datrd   (m0_datrd),
    .io_m0_we      (m0_we),
    .io_m0_stb     (m0_stb),
    .io_m0_cyc     (m0_cyc),
    .io_m0_ack     (m0_ack),
    .io_m1_adr     (m1_adr),
    .io_m1_datwr   (m1_datwr),
    .io_m1_datrd   (m1_datrd),
    .io_m1_we      (m1_we),
    .io_m1_stb     (m1_stb),
    .io_m1_cyc     (m1_cyc),
    .io_m1_ack     (m1_ack),
    .io_s_adr      (s_adr),
    .io_s_datwr    (s_datwr),
    .io_s_datrd    (s_datrd),
    .io_s_we       (s_we),
    .io_s_stb      (s_stb),
    .io_s_cyc      (s_cyc),
    .io_s_ack      (s_ack),
    .arb_grant_o   (grant),
    .arb_timeout_o (timeout)
  );

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rd;
    logic        we;
  } txn_t;

  txn_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: one line per completed slave beat
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : mon
    txn_t        e;
    logic [1:0]  acks_exp;
    logic [31:0] own_rd, oth_rd;
    logic        ok;
    if (!rst && s_stb && s_ack) begin
      n_checks++;
      n_txn++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: adr=%h we=%b got access, required none", s_adr, s_we);
      end else begin
        e        = sb_q.pop_front();
        acks_exp = (e.m == 0) ? 2'b01 : 2'b10;
        own_rd   = (e.m == 0) ? m0_datrd : m1_datrd;
        oth_rd   = (e.m == 0) ? m1_datrd : m0_datrd;
        ok = (s_adr === e.adr) && (s_we === e.we) && (!e.we || s_datwr === e.dat) &&
             ({m1_ack, m0_ack} === acks_exp) && (oth_rd === 32'h0) &&
             (e.we || own_rd === e.rd);
        if (!ok) begin
          n_fail++;
          $display("FAIL beat_%0d: got m%0d-side adr=%h we=%b wd=%h acks=%b rd=%h/%h, required m%0d adr=%h we=%b wd=%h rd=%h",
                   n_txn, e.m, s_adr, s_we, s_datwr, {m1_ack, m0_ack}, own_rd, oth_rd,
                   e.m, e.adr, e.we, e.dat, e.rd);
        end else begin
          $display("txn %0d: m%0d %s adr=%h data=%h ok", n_txn, e.m, e.we ? "wr" : "rd",
                   e.adr, e.we ? e.dat : e.rd);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drive helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_datwr = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_datwr = dat;
    end
  endtask

  task automatic push(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [31:0] rd);
    txn_t t;
    t.m = m; t.we = we; t.adr = adr; t.dat = dat; t.rd = rd;
    sb_q.push_back(t);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios (each starts and ends just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; s_ack = 1'b0; s_datrd = '0;
    drive_m(0, 0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({grant, s_cyc, s_stb, s_we, m0_ack, m1_ack, timeout, s_adr, s_datwr, m0_datrd, m1_datrd} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle_%0d: grant=%b s_cyc=%b s_stb=%b acks=%b%b s_adr=%h, required all 0",
                 i, grant, s_cyc, s_stb, m1_ack, m0_ack, s_adr);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_m0();
    drive_m(0, 1, 1, 1, 32'h10, 32'hA5A5_A5A5);
    push(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({s_cyc, grant} !== 3'b0_00) begin
      n_fail++;
      $display("FAIL m0_latency: s_cyc=%b grant=%b, required 0/00", s_cyc, grant);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({s_cyc, s_stb, grant, m0_ack, s_adr} !== {4'b1_1_01, 1'b0, 32'h10}) begin
      n_fail++;
      $display("FAIL m0_grant: s_cyc=%b s_stb=%b grant=%b ack=%b adr=%h, required 1/1/01/0/00000010",
               s_cyc, s_stb, grant, m0_ack, s_adr);
    end
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL m0_ack_track: m0_ack=%b m1_ack=%b, required 1/0", m0_ack, m1_ack);
    end
    next_cycle();
    drive_m(0, 1, 1, 0, 32'h14, 32'h0);
    s_datrd = 32'h1234_5678;
    push(0, 1'b0, 32'h14, 32'h0, 32'h1234_5678);
    @(negedge clk);
    next_cycle();
    s_ack = 1'b0; s_datrd = '0;
    drive_m(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if ({s_cyc, m0_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL m0_release: s_cyc=%b m0_ack=%b, required 0/0", s_cyc, m0_ack);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL m0_idle: grant=%b, required 00", grant);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [1:0] seq_got[4];
    logic [1:0] seq_exp[4];
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    // First tie after reset: m0 must win.
    drive_m(0, 1, 1, 1, 32'h20, 32'h1);
    drive_m(1, 1, 1, 1, 32'h30, 32'h2);
    @(negedge clk);
    next_cycle();
    s_ack = 1'b1;
    push(0, 1'b1, 32'h20, 32'h1, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({grant, m1_ack} !== 3'b01_0) begin
      n_fail++;
      $display("FAIL rr_tie1: grant=%b m1_ack=%b, required 01/0", grant, m1_ack);
    end
    next_cycle();
    s_ack = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      next_cycle();
    end
    // Second tie: m0 was served last, so m1 must win; m0 follows after a dead cycle.
    drive_m(0, 1, 1, 1, 32'h24, 32'h4);
    drive_m(1, 1, 1, 1, 32'h34, 32'h3);
    @(negedge clk);
    next_cycle();
    s_ack = 1'b1;
    push(1, 1'b1, 32'h34, 32'h3, 32'h0);
    @(negedge clk);
    seq_got[0] = grant;
    next_cycle();
    s_ack = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    seq_got[1] = grant;
    n_checks++;
    if (s_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drop_cycle: s_cyc=%b, required 0", s_cyc);
    end
    next_cycle();
    @(negedge clk);
    seq_got[2] = grant;
    n_checks++;
    if (s_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_dead_cycle: s_cyc=%b, required 0", s_cyc);
    end
    next_cycle();
    s_ack = 1'b1;
    push(0, 1'b1, 32'h24, 32'h4, 32'h0);
    @(negedge clk);
    seq_got[3] = grant;
    seq_exp[0] = 2'b10; seq_exp[1] = 2'b10; seq_exp[2] = 2'b00; seq_exp[3] = 2'b01;
    n_checks++;
    if (seq_got !== seq_exp) begin
      n_fail++;
      $display("FAIL rr_sequence: grants=%b,%b,%b,%b, required 10,10,00,01",
               seq_got[0], seq_got[1], seq_got[2], seq_got[3]);
    end
    next_cycle();
    s_ack = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();
  endtask

  task automatic test_back_to_back();
    drive_m(1, 1, 1, 1, 32'h40, 32'h100);
    @(negedge clk);
    next_cycle();
    drive_m(0, 1, 1, 1, 32'h50, 32'h55);
    for (int k = 0; k < 4; k++) begin
      drive_m(1, 1, 1, 1, 32'h40 + 32'(4 * k), 32'h100 + 32'(k));
      s_ack = 1'b1;
      push(1, 1'b1, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), 32'h0);
      @(negedge clk);
      n_checks++;
      if ({grant, m0_ack} !== 3'b10_0) begin
        n_fail++;
        $display("FAIL burst_beat_%0d: grant=%b m0_ack=%b, required 10/0", k, grant, m0_ack);
      end
      next_cycle();
    end
    s_ack = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant, s_cyc, m0_ack} !== 4'b00_0_0) begin
      n_fail++;
      $display("FAIL burst_dead: grant=%b s_cyc=%b m0_ack=%b, required 00/0/0", grant, s_cyc, m0_ack);
    end
    next_cycle();
    s_ack = 1'b1;
    push(0, 1'b1, 32'h50, 32'h55, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({grant, s_cyc} !== 3'b01_1) begin
      n_fail++;
      $display("FAIL burst_handover: grant=%b s_cyc=%b, required 01/1", grant, s_cyc);
    end
    next_cycle();
    s_ack = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_m(0, 1, 1, 1, 32'h60, 32'h66);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant, s_stb} !== 3'b01_1) begin
      n_fail++;
      $display("FAIL rstmid_setup: grant=%b s_stb=%b, required 01/1", grant, s_stb);
    end
    next_cycle();
    rst   = 1'b1;
    s_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_ack: m0_ack=%b, required 0", m0_ack);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_cyc, grant, m0_ack} !== 4'b0_00_0) begin
      n_fail++;
      $display("FAIL rstmid_abort: s_cyc=%b grant=%b m0_ack=%b, required 0/00/0", s_cyc, grant, m0_ack);
    end
    next_cycle();
    s_ack = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
  endtask

  task automatic test_timeout();
    int   stb_cycles;
    logic got_ack;
    stb_cycles = 0;
    got_ack    = 1'b0;
    s_ack      = 1'b0;
    drive_m(0, 1, 1, 1, 32'h70, 32'h77);
    @(negedge clk);
    next_cycle();
    drive_m(1, 1, 1, 1, 32'h80, 32'h88);
`ifdef WFG_ARB_TIMEOUT_EN
    for (int i = 0; i < 20 && !got_ack; i++) begin
      @(negedge clk);
      if (m0_ack) begin
        got_ack = 1'b1;
      end else begin
        if (grant == 2'b01 && s_stb) stb_cycles++;
        next_cycle();
      end
    end
    n_checks++;
    if (!got_ack || stb_cycles != 8 || m0_datrd !== 32'hDEAD_BEEF || {s_cyc, s_stb} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_abort: ack=%b after %0d stb cycles datrd=%h s_cyc/stb=%b%b, required 1 after 8, DEADBEEF, 00",
               got_ack, stb_cycles, m0_datrd, s_cyc, s_stb);
    end
    next_cycle();
    drive_m(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if ({timeout, grant} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL timeout_flag: timeout=%b grant=%b, required 1/00", timeout, grant);
    end
    next_cycle();
    s_ack = 1'b1;
    push(1, 1'b1, 32'h80, 32'h88, 32'h0);
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_handover: grant=%b, required 10", grant);
    end
    next_cycle();
    s_ack = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
`else
    // Without the watchdog a silent slave keeps m0 granted indefinitely.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_ack) got_ack = 1'b1;
      if (grant == 2'b01 && s_stb) stb_cycles++;
      next_cycle();
    end
    n_checks++;
    if (got_ack || stb_cycles != 20 || timeout !== 1'b0 || grant !== 2'b01) begin
      n_fail++;
      $display("FAIL hung_slave: ack=%b stb_cycles=%0d timeout=%b grant=%b, required 0/20/0/01",
               got_ack, stb_cycles, timeout, grant);
    end
    drive_m(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    s_ack = 1'b1;
    push(1, 1'b1, 32'h80, 32'h88, 32'h0);
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL hung_release: grant=%b, required 10", grant);
    end
    next_cycle();
    s_ack = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
`endif
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d beats never completed, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
